// File: rtl/router_pkt_tx.sv
// Packet transmitter toward a router port: header, payload bytes, then parity,
// followed by a programmable idle gap before the next packet is accepted.
module router_pkt_tx #(
  parameter int IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic       inj_err,
  input  logic [7:0] pl_data,
  output logic       pl_req,
  input  logic       busy,
  output logic       rdy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       done,
  output logic       err
);

  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

  state_t          state;
  logic [1:0]      addr;
  logic [5:0]      len;
  logic            inj;
  logic [7:0]      acc;
  logic [5:0]      cnt;
  logic [GW-1:0]   gap_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      inj       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      gap_cnt   <= '0;
      rdy       <= 1'b1;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (dest_addr != 2'd3 && payload_len != 6'd0) begin
              addr      <= dest_addr;
              len       <= payload_len;
              inj       <= inj_err;
              state     <= HEADER;
              rdy       <= 1'b0;
              pkt_valid <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            state <= PAYLOAD;
            acc   <= {len, addr};
            cnt   <= len;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            acc <= acc ^ pl_data;
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) begin
              state     <= PARITY;
              pkt_valid <= 1'b0;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            state   <= GAP;
            done    <= 1'b1;
            gap_cnt <= GW'(IDLE_GAP - 1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            rdy   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          rdy       <= 1'b1;
          pkt_valid <= 1'b0;
        end
      endcase
    end
  end

  // Payload bytes pass straight through so the FWFT buffer head is sent the
  // same cycle it is popped; all other bytes come from registered state.
  always_comb begin
    data_out = 8'h00;
    pl_req   = 1'b0;
    case (state)
      HEADER:  data_out = {len, addr};
      PAYLOAD: begin
        data_out = pl_data;
        pl_req   = ~busy;
      end
      PARITY:  data_out = acc ^ {7'b0, inj};
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 1, number of idle cycles (>=1) after each parity byte before rdy reasserts.
REQ-002 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high reset.
  start  in  1  user request to send one packet; sampled only when rdy=1.
  dest_addr  in  2  destination port 0..2, sampled with start.
  payload_len  in  6  payload byte count 1..63, sampled with start.
  inj_err  in  1  sampled with start; 1 = transmit corrupted parity.
  pl_data  in  8  current payload byte from a first-word-fall-through user buffer.
  pl_req  out  1  pop strobe to user buffer; 1 on each cycle a payload byte is accepted.
  busy  in  1  router backpressure; byte on data_out is accepted only at a rising edge where busy=0.
  rdy  out  1  1 = idle, start will be taken.
  pkt_valid  out  1  packet-valid to router.
  data_out  out  8  byte to router.
  done  out  1  one-cycle pulse after parity byte accepted.
  err  out  1  one-cycle pulse on rejected start.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.

Function
REQ-004 SHALL implement states IDLE, HEADER, PAYLOAD, PARITY, GAP.
REQ-005 IDLE: rdy=1, pkt_valid=0, data_out=0; start=1 with dest_addr<=2 and payload_len!=0 SHALL latch addr, len, inj_err and go to HEADER next cycle.
REQ-006 IDLE: start=1 with dest_addr=3 or payload_len=0 SHALL stay IDLE and pulse err for exactly one cycle (registered, cycle after start).
REQ-007 start while rdy=0 SHALL be ignored with no err.
REQ-008 HEADER: pkt_valid=1, data_out={len[5:0],addr[1:0]}, held while busy=1; at edge with busy=0 go PAYLOAD, parity accumulator <= header byte, byte counter <= len.
REQ-009 PAYLOAD: pkt_valid=1, data_out=pl_data (combinational pass-through); pl_req = ~busy; each accepted byte XORed into accumulator, counter decremented.
REQ-010 PAYLOAD: acceptance of the byte with counter=1 SHALL go PARITY; no further pl_req for that packet; exactly len pl_req pulses per packet.
REQ-011 PARITY: pkt_valid=0, data_out=accumulator XOR {7'b0,inj_err}, held while busy=1; at edge with busy=0 go GAP.
REQ-012 done SHALL be 1 for exactly the first cycle of GAP.
REQ-013 GAP: pkt_valid=0, data_out=0, rdy=0 for IDLE_GAP cycles, then IDLE.
REQ-014 busy SHALL be sampled every cycle; any number of stall cycles per byte, including stalls on header and parity, SHALL not lose, duplicate or reorder bytes.
REQ-015 pkt_valid, rdy, done, err SHALL be glitch-free decodes of registered state; data_out only depends combinationally on pl_data in PAYLOAD.
REQ-016 Parity SHALL be bytewise XOR of header and all payload bytes, 8 bits, no carry.

Reset
REQ-017 reset=1 SHALL immediately (without clock) force IDLE, pkt_valid=0, data_out=0, pl_req=0, done=0, err=0, rdy=1, counters/accumulator 0.
REQ-018 reset mid-packet SHALL abandon the packet; no parity sent; next start after reset release starts a fresh packet.

Verification
REQ-019 addr=1, len=3, payload A5,3C,FF, busy=0 -> data_out 0D,A5,3C,FF (pkt_valid=1) then 6B (pkt_valid=0), done one cycle later, 3 pl_req pulses.
REQ-020 Same packet, busy=1 for 4 cycles on header and 2 cycles on 2nd payload byte -> identical byte sequence, each byte held stable during stall, pl_req only on accepted cycles.
REQ-021 start with addr=3 len=5, then addr=0 len=0 -> err pulses twice, pkt_valid never asserts, rdy stays 1.
REQ-022 addr=1, len=3, A5,3C,FF, inj_err=1 -> parity byte 6A; next packet with inj_err=0 -> correct parity.
REQ-023 addr=2, len=63, all bytes 00 -> header FE, 63 payload cycles, parity FE; back-to-back start held high -> next header exactly IDLE_GAP+1 cycles after done.
REQ-024 reset asserted during 2nd payload byte -> outputs reset same cycle, rdy=1 after release, following packet correct.
